control_fsm: RTL and testbench
==============================

# control_fsm

Multi-cycle control unit sitting directly upstream of the datapath. It sequences fetch, decode and execute for every instruction. It decodes the latched instruction word and drives every datapath select and enable line, plus the memory write strobe. It also owns the multi-cycle raycast triangle-load sequence.

## Interface
- `RAY_WORDS`, 4: words loaded into raycast registers 4..7 by RAYLD.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `instruction`  in  16  latched instruction register contents from the datapath.
- `instruction_write_enable`, `program_counter_write_enable`, `status_write_enable`, `register_write_enable`, `raycast_write_enable`, `memory_write_enable`  out  1 each  write strobes.
- `alu_a_select`, `alu_b_select`, `program_counter_select`, `memory_address_select`  out  2 each  datapath mux selects.
- `alu_operation`, `register_write_data_select`, `register_write_data_select_extra`, `raycast_write_select`, `memory_offset`  out  3 each  operation and select codes.

## Operation
- Field split: opcode [15:12]; ext [7:4]. Opcode 0000 is register-register, selected by ext. Opcodes 0001/0010/0011/0101/1001/1011/1101/1110 are ANDI/ORI/XORI/ADDI/SUBI/CMPI/MOVI/MULI. 1111 is LUI; 1000 is shift (ext 0100 LSH, ext 000x LSHI); 1100 is Bcond.
- Opcode 0100 by ext: 0000 LOAD, 0100 STOR, 1000 JAL, 1100 Jcond.
- Opcode 0111 by ext: 0000 SIN, 0001 COS, 0010 RAYP1, 0011 RAYP2, 0100 RAYLD, 0101 RAYDIST, 0110 RAYTUV.
- ALU ops (alu_operation codes: ADD 0, SUB 1, CMP 2, AND 3, OR 4, XOR 5, SHIFT 6, MUL 7):
  - Register-register forms use alu_a=1 (source), alu_b=0, write select 0.
  - Immediate forms use alu_a=2 (sign-extended) for ADDI/SUBI/CMPI/MULI and alu_a=3 (zero-extended) for logicals.
  - CMP/CMPI never write a register.
- `status_write_enable`=1 only in EXECUTE of ADD/ADDI/SUB/SUBI/CMP/CMPI.
- MOV: write select 1. MOVI: write select 2. LUI: write select 3.
- LOAD: memory_address_select=1; write select 4, written in LOAD_WAIT.
- STOR: memory_address_select=2, memory_offset=0, `memory_write_enable`=1 for one cycle.
- Bcond: alu_a=0, alu_b=2, ADD, program_counter_select=1.
- Jcond: program_counter_select=2.
- JAL: write select 5 into the destination register, alu_a=1, alu_b=3, OR, program_counter_select=1, all in the same cycle.
- SIN/COS: write select 7, extra 0/1. RAYDIST/RAYTUV: write select 7, extra 2/3.
- RAYP1/RAYP2: `raycast_write_enable`=1, raycast_write_select 000/010.
- RAYLD: state RAY_LOAD with 3-bit counter c = 0..RAY_WORDS.
  - In cycle c (c<RAY_WORDS): memory_address_select=2, memory_offset=c.
  - In cycle c (c≥1): raycast_write_enable=1, raycast_write_select=4+c-1.
- Every instruction except jumps, branches and JAL ends with program_counter_select=0 and PC write enabled.
- Unrecognised encodings execute as NOP: PC increments, no other writes.

## Timing
- States: FETCH → FETCH_WAIT → DECODE → EXECUTE → FETCH, with EXECUTE → LOAD_WAIT → FETCH and EXECUTE → RAY_LOAD → FETCH.
- Memory read latency is exactly one cycle.
  - FETCH and FETCH_WAIT drive memory_address_select=0.
  - `instruction_write_enable`=1 only in FETCH_WAIT.
- Cycle counts:
  - ALU, jump, branch, STOR, trig and raycast-register instructions: 4 cycles.
  - LOAD: 5 cycles.
  - RAYLD: 4 + RAY_WORDS + 1 = 9 cycles.
- The PC write occurs in the final cycle of each instruction.
- All outputs are a Moore/Mealy function of state and `instruction` only; no output depends on datapath flags.
- Reset: state is forced to FETCH asynchronously and the RAYLD counter to 0. All enables are 0, all selects and codes are 0, memory_address_select=0.
- Reset asserted mid-RAYLD or mid-LOAD aborts with no further writes; execution restarts from FETCH of the current PC.

## Configuration
- `CONTROL_FSM_RAYCAST_EN` defined: opcode 0111 decoded as above and RAY_LOAD state present.
- Undefined: opcode 0111 is NOP. `raycast_write_enable` is tied 0, extra select is tied 0, and RAY_LOAD is absent.

## Structure
- `control_pkg`: state enum; opcode/ext constants; alu_operation, alu_a/alu_b, PC, register-write, extra and memory-address select constants.
- Sub-module `instruction_decode` (combinational): maps `instruction` to an execute control bundle and an instruction class (alu, load, store, rayld, nop). `control_fsm` holds the state register, the RAYLD counter and the per-state gating.

## Test plan
- Reset, then release: first cycle shows FETCH with all enables 0. After 2 cycles `instruction_write_enable`=1 exactly once.
- instruction 16'h0351 (ADD r3,r1): EXECUTE shows alu_operation 0, alu_a 1, alu_b 0, register and status writes 1, PC write 1. The instruction completes in 4 cycles.
- instruction 16'h4204 (LOAD r2,[r4]): memory_address_select 1 in EXECUTE; register_write_enable with select 4 only in LOAD_WAIT; 5 cycles total.
- instruction 16'h7540 (RAYLD r5): memory_offset sequence 0,1,2,3, raycast_write_select sequence 4,5,6,7 lagging by one cycle. There are exactly 4 raycast writes, and 9 cycles total.
- instruction 16'h4E81 (JAL r14,r1): register write select 5, alu OR with alu_b 3, PC select 1, all in the same cycle.
- Reset asserted during RAY_LOAD c=2: all enables drop immediately and no further raycast write occurs. Built without the macro, 16'h7540 performs only a PC increment.

Source files
------------

// File: rtl/control_pkg.sv
// Shared constants, control bundle and helpers for the multi-cycle control unit.
// Opcode/ext codes, select encodings and FSM state codes live here.
package control_pkg;

  localparam int RAY_WORDS = 4;
  localparam logic [2:0] RAY_LAST = 3'(RAY_WORDS);

  localparam logic [2:0] S_FETCH      = 3'd0;
  localparam logic [2:0] S_FETCH_WAIT = 3'd1;
  localparam logic [2:0] S_DECODE     = 3'd2;
  localparam logic [2:0] S_EXECUTE    = 3'd3;
  localparam logic [2:0] S_LOAD_WAIT  = 3'd4;
  localparam logic [2:0] S_RAY_LOAD   = 3'd5;

  // ALU function codes; immediate opcodes reuse the register-form ext codes
  localparam logic [3:0] F_AND = 4'b0001;
  localparam logic [3:0] F_OR  = 4'b0010;
  localparam logic [3:0] F_XOR = 4'b0011;
  localparam logic [3:0] F_ADD = 4'b0101;
  localparam logic [3:0] F_SUB = 4'b1001;
  localparam logic [3:0] F_CMP = 4'b1011;
  localparam logic [3:0] F_MOV = 4'b1101;
  localparam logic [3:0] F_MUL = 4'b1110;

  localparam logic [3:0] OP_RR    = 4'b0000;
  localparam logic [3:0] OP_ANDI  = F_AND;
  localparam logic [3:0] OP_ORI   = F_OR;
  localparam logic [3:0] OP_XORI  = F_XOR;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_ADDI  = F_ADD;
  localparam logic [3:0] OP_SPEC  = 4'b0111;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_SUBI  = F_SUB;
  localparam logic [3:0] OP_CMPI  = F_CMP;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_MOVI  = F_MOV;
  localparam logic [3:0] OP_MULI  = F_MUL;
  localparam logic [3:0] OP_LUI   = 4'b1111;

  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;
  localparam logic [3:0] EXT_LSH   = 4'b0100;

  localparam logic [3:0] EXT_SIN     = 4'd0;
  localparam logic [3:0] EXT_COS     = 4'd1;
  localparam logic [3:0] EXT_RAYP1   = 4'd2;
  localparam logic [3:0] EXT_RAYP2   = 4'd3;
  localparam logic [3:0] EXT_RAYLD   = 4'd4;
  localparam logic [3:0] EXT_RAYDIST = 4'd5;
  localparam logic [3:0] EXT_RAYTUV  = 4'd6;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_CMP   = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd3;
  localparam logic [2:0] ALU_OR    = 3'd4;
  localparam logic [2:0] ALU_XOR   = 3'd5;
  localparam logic [2:0] ALU_SHIFT = 3'd6;
  localparam logic [2:0] ALU_MUL   = 3'd7;

  localparam logic [1:0] ASEL_PC   = 2'd0;
  localparam logic [1:0] ASEL_REG  = 2'd1;
  localparam logic [1:0] ASEL_SEXT = 2'd2;
  localparam logic [1:0] ASEL_ZEXT = 2'd3;

  localparam logic [1:0] BSEL_DST  = 2'd0;
  localparam logic [1:0] BSEL_DISP = 2'd2;
  localparam logic [1:0] BSEL_LINK = 2'd3;

  localparam logic [1:0] PCSEL_INC = 2'd0;
  localparam logic [1:0] PCSEL_ALU = 2'd1;
  localparam logic [1:0] PCSEL_REG = 2'd2;

  localparam logic [2:0] RW_ALU   = 3'd0;
  localparam logic [2:0] RW_SRC   = 3'd1;
  localparam logic [2:0] RW_IMM   = 3'd2;
  localparam logic [2:0] RW_UPPER = 3'd3;
  localparam logic [2:0] RW_MEM   = 3'd4;
  localparam logic [2:0] RW_LINK  = 3'd5;
  localparam logic [2:0] RW_EXTRA = 3'd7;

  localparam logic [2:0] EX_SIN  = 3'd0;
  localparam logic [2:0] EX_COS  = 3'd1;
  localparam logic [2:0] EX_DIST = 3'd2;
  localparam logic [2:0] EX_TUV  = 3'd3;

  localparam logic [1:0] MA_PC   = 2'd0;
  localparam logic [1:0] MA_SRC  = 2'd1;
  localparam logic [1:0] MA_OFFS = 2'd2;

  localparam logic [2:0] CLS_ALU   = 3'd0;
  localparam logic [2:0] CLS_LOAD  = 3'd1;
  localparam logic [2:0] CLS_STORE = 3'd2;
  localparam logic [2:0] CLS_RAYLD = 3'd3;
  localparam logic [2:0] CLS_NOP   = 3'd4;

  typedef struct packed {
    logic       pc_we;
    logic       status_we;
    logic       reg_we;
    logic       ray_we;
    logic       mem_we;
    logic [2:0] alu_op;
    logic [1:0] alu_a;
    logic [1:0] alu_b;
    logic [1:0] pc_sel;
    logic [1:0] mem_sel;
    logic [2:0] rw_sel;
    logic [2:0] rw_extra;
    logic [2:0] ray_sel;
    logic [2:0] mem_offset;
  } exec_ctl_t;

  // {valid, alu_op} for an ALU function code
  function automatic logic [3:0] alu_decode(input logic [3:0] f);
    unique case (f)
      F_AND:   return {1'b1, ALU_AND};
      F_OR:    return {1'b1, ALU_OR};
      F_XOR:   return {1'b1, ALU_XOR};
      F_ADD:   return {1'b1, ALU_ADD};
      F_SUB:   return {1'b1, ALU_SUB};
      F_CMP:   return {1'b1, ALU_CMP};
      F_MUL:   return {1'b1, ALU_MUL};
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic sets_status(input logic [3:0] f);
    return (f == F_ADD) || (f == F_SUB) || (f == F_CMP);
  endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Control-unit to datapath bundle: instruction word in, strobes and selects out.
// master = control unit, slave = datapath.
interface control_fsm_if;
  logic [15:0] instruction;
  logic        instruction_write_enable;
  logic        program_counter_write_enable;
  logic        status_write_enable;
  logic        register_write_enable;
  logic        raycast_write_enable;
  logic        memory_write_enable;
  logic [1:0]  alu_a_select;
  logic [1:0]  alu_b_select;
  logic [1:0]  program_counter_select;
  logic [1:0]  memory_address_select;
  logic [2:0]  alu_operation;
  logic [2:0]  register_write_data_select;
  logic [2:0]  register_write_data_select_extra;
  logic [2:0]  raycast_write_select;
  logic [2:0]  memory_offset;

  modport master (
    input  instruction,
    output instruction_write_enable, program_counter_write_enable,
    output status_write_enable, register_write_enable,
    output raycast_write_enable, memory_write_enable,
    output alu_a_select, alu_b_select,
    output program_counter_select, memory_address_select,
    output alu_operation, register_write_data_select,
    output register_write_data_select_extra,
    output raycast_write_select, memory_offset
  );

  modport slave (
    output instruction,
    input  instruction_write_enable, program_counter_write_enable,
    input  status_write_enable, register_write_enable,
    input  raycast_write_enable, memory_write_enable,
    input  alu_a_select, alu_b_select,
    input  program_counter_select, memory_address_select,
    input  alu_operation, register_write_data_select,
    input  register_write_data_select_extra,
    input  raycast_write_select, memory_offset
  );
endinterface

// File: rtl/control_fsm_decode.sv
// Combinational instruction decoder producing the EXECUTE-cycle control bundle.
// Opcode 0111 is decoded only when CONTROL_FSM_RAYCAST_EN is defined.
module instruction_decode
  import control_pkg::*;
(
  input  logic [15:0] instruction,
  output exec_ctl_t   ctl,
  output logic [2:0]  cls
);

  logic [3:0] op;
  logic [3:0] ext;
  logic [3:0] rr_dec;
  logic [3:0] im_dec;
  logic       unused_bits;

  assign op          = instruction[15:12];
  assign ext         = instruction[7:4];
  assign rr_dec      = alu_decode(ext);
  assign im_dec      = alu_decode(op);
  assign unused_bits = ^{instruction[11:8], instruction[3:0]};

  always_comb begin
    ctl       = '0;
    cls       = CLS_NOP;
    ctl.pc_we = 1'b1;
    unique case (op)
      OP_RR: begin
        if (rr_dec[3]) begin
          cls           = CLS_ALU;
          ctl.alu_op    = rr_dec[2:0];
          ctl.alu_a     = ASEL_REG;
          ctl.reg_we    = (ext != F_CMP);
          ctl.status_we = sets_status(ext);
        end else if (ext == F_MOV) begin
          cls        = CLS_ALU;
          ctl.alu_a  = ASEL_REG;
          ctl.reg_we = 1'b1;
          ctl.rw_sel = RW_SRC;
        end
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        cls        = CLS_ALU;
        ctl.alu_op = im_dec[2:0];
        ctl.alu_a  = ASEL_ZEXT;
        ctl.reg_we = 1'b1;
      end
      OP_ADDI, OP_SUBI, OP_CMPI, OP_MULI: begin
        cls           = CLS_ALU;
        ctl.alu_op    = im_dec[2:0];
        ctl.alu_a     = ASEL_SEXT;
        ctl.reg_we    = (op != OP_CMPI);
        ctl.status_we = sets_status(op);
      end
      OP_MOVI: begin
        cls        = CLS_ALU;
        ctl.reg_we = 1'b1;
        ctl.rw_sel = RW_IMM;
      end
      OP_LUI: begin
        cls        = CLS_ALU;
        ctl.reg_we = 1'b1;
        ctl.rw_sel = RW_UPPER;
      end
      OP_SHIFT: begin
        if (ext == EXT_LSH || ext[3:1] == 3'b000) begin
          cls        = CLS_ALU;
          ctl.alu_op = ALU_SHIFT;
          ctl.alu_a  = (ext == EXT_LSH) ? ASEL_REG : ASEL_SEXT;
          ctl.reg_we = 1'b1;
        end
      end
      OP_BCOND: begin
        cls        = CLS_ALU;
        ctl.alu_op = ALU_ADD;
        ctl.alu_a  = ASEL_PC;
        ctl.alu_b  = BSEL_DISP;
        ctl.pc_sel = PCSEL_ALU;
      end
      OP_MEM: begin
        unique case (ext)
          EXT_LOAD: begin
            cls         = CLS_LOAD;
            ctl.pc_we   = 1'b0;
            ctl.mem_sel = MA_SRC;
          end
          EXT_STOR: begin
            cls         = CLS_STORE;
            ctl.mem_sel = MA_OFFS;
            ctl.mem_we  = 1'b1;
          end
          EXT_JAL: begin
            cls        = CLS_ALU;
            ctl.reg_we = 1'b1;
            ctl.rw_sel = RW_LINK;
            ctl.alu_op = ALU_OR;
            ctl.alu_a  = ASEL_REG;
            ctl.alu_b  = BSEL_LINK;
            ctl.pc_sel = PCSEL_ALU;
          end
          EXT_JCOND: begin
            cls        = CLS_ALU;
            ctl.pc_sel = PCSEL_REG;
          end
          default: ;
        endcase
      end
`ifdef CONTROL_FSM_RAYCAST_EN
      OP_SPEC: begin
        unique case (ext)
          EXT_SIN, EXT_COS, EXT_RAYDIST, EXT_RAYTUV: begin
            cls          = CLS_ALU;
            ctl.reg_we   = 1'b1;
            ctl.rw_sel   = RW_EXTRA;
            ctl.rw_extra = (ext == EXT_SIN) ? EX_SIN :
                           (ext == EXT_COS) ? EX_COS :
                           (ext == EXT_RAYDIST) ? EX_DIST : EX_TUV;
          end
          EXT_RAYP1, EXT_RAYP2: begin
            cls         = CLS_ALU;
            ctl.ray_we  = 1'b1;
            ctl.ray_sel = (ext == EXT_RAYP1) ? 3'b000 : 3'b010;
          end
          EXT_RAYLD: begin
            cls       = CLS_RAYLD;
            ctl.pc_we = 1'b0;
          end
          default: ;
        endcase
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle fetch/decode/execute sequencer driving datapath selects and strobes.
// CONTROL_FSM_RAYCAST_EN enables the raycast opcodes and the RAY_LOAD state.
module control_fsm
  import control_pkg::*;
(
  input logic           clock,
  input logic           reset,
  control_fsm_if.master bus
);

  logic [2:0] state;
  logic [2:0] state_n;
  logic [2:0] cls;
  logic       ir_we;
  exec_ctl_t  ctl;
  exec_ctl_t  drv;
`ifdef CONTROL_FSM_RAYCAST_EN
  logic [2:0] cnt;
`endif

  instruction_decode u_dec (
    .instruction (bus.instruction),
    .ctl         (ctl),
    .cls         (cls)
  );

  always_comb begin
    state_n = S_FETCH;
    unique case (state)
      S_FETCH:      state_n = S_FETCH_WAIT;
      S_FETCH_WAIT: state_n = S_DECODE;
      S_DECODE:     state_n = S_EXECUTE;
      S_EXECUTE: begin
        unique case (1'b1)
          (cls == CLS_LOAD):  state_n = S_LOAD_WAIT;
`ifdef CONTROL_FSM_RAYCAST_EN
          (cls == CLS_RAYLD): state_n = S_RAY_LOAD;
`endif
          default:            state_n = S_FETCH;
        endcase
      end
`ifdef CONTROL_FSM_RAYCAST_EN
      S_RAY_LOAD:
        state_n = (cnt == RAY_LAST) ? S_FETCH : S_RAY_LOAD;
`endif
      default:      state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_n;
  end

`ifdef CONTROL_FSM_RAYCAST_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (state == S_RAY_LOAD)
      cnt <= (cnt == RAY_LAST) ? 3'd0 : cnt + 3'd1;
  end
`endif

  always_comb begin
    drv   = '0;
    ir_we = 1'b0;
    unique case (state)
      S_FETCH_WAIT: ir_we = 1'b1;
      S_EXECUTE:    drv   = ctl;
      S_LOAD_WAIT: begin
        drv.mem_sel = MA_SRC;
        drv.reg_we  = 1'b1;
        drv.rw_sel  = RW_MEM;
        drv.pc_we   = 1'b1;
      end
`ifdef CONTROL_FSM_RAYCAST_EN
      // address word c while writing word c-1 fetched last cycle
      S_RAY_LOAD: begin
        if (cnt != RAY_LAST) begin
          drv.mem_sel    = MA_OFFS;
          drv.mem_offset = cnt;
        end
        if (cnt != 3'd0) begin
          drv.ray_we  = 1'b1;
          drv.ray_sel = cnt + 3'd3;
        end
        drv.pc_we = (cnt == RAY_LAST);
      end
`endif
      default: ;
    endcase
  end

  assign bus.instruction_write_enable     = ir_we;
  assign bus.program_counter_write_enable = drv.pc_we;
  assign bus.status_write_enable          = drv.status_we;
  assign bus.register_write_enable        = drv.reg_we;
  assign bus.memory_write_enable          = drv.mem_we;
  assign bus.alu_a_select                 = drv.alu_a;
  assign bus.alu_b_select                 = drv.alu_b;
  assign bus.program_counter_select       = drv.pc_sel;
  assign bus.memory_address_select        = drv.mem_sel;
  assign bus.alu_operation                = drv.alu_op;
  assign bus.register_write_data_select   = drv.rw_sel;
  assign bus.memory_offset                = drv.mem_offset;

`ifdef CONTROL_FSM_RAYCAST_EN
  assign bus.raycast_write_enable             = drv.ray_we;
  assign bus.raycast_write_select             = drv.ray_sel;
  assign bus.register_write_data_select_extra = drv.rw_extra;
`else
  logic unused_ray;
  assign unused_ray = ^{drv.ray_we, drv.ray_sel, drv.rw_extra};
  assign bus.raycast_write_enable             = 1'b0;
  assign bus.raycast_write_select             = 3'd0;
  assign bus.register_write_data_select_extra = 3'd0;
`endif

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: per-state strobe/select checks with
// hand-computed vectors; raycast steps follow CONTROL_FSM_RAYCAST_EN.
module tb_control_fsm;

  localparam logic [5:0] IR = 6'b100000;
  localparam logic [5:0] PC = 6'b010000;
  localparam logic [5:0] ST = 6'b001000;
  localparam logic [5:0] RG = 6'b000100;
  localparam logic [5:0] RY = 6'b000010;
  localparam logic [5:0] MW = 6'b000001;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   ray_count = 0;

  control_fsm_if bus ();

  control_fsm u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [5:0]  en;
  logic [22:0] sels;
  assign en = {bus.instruction_write_enable, bus.program_counter_write_enable,
               bus.status_write_enable, bus.register_write_enable,
               bus.raycast_write_enable, bus.memory_write_enable};
  assign sels = {bus.alu_a_select, bus.alu_b_select,
                 bus.program_counter_select, bus.memory_address_select,
                 bus.alu_operation, bus.register_write_data_select,
                 bus.register_write_data_select_extra,
                 bus.raycast_write_select, bus.memory_offset};

  always @(posedge clock)
    if (bus.raycast_write_enable) ray_count <= ray_count + 1;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s ins=%h observed=%h expected=%h",
             tag, bus.instruction, obs, exp);
    end
  endtask

  task automatic chk_ex(input string tag, input logic [5:0] e,
                        input logic [2:0] op, input logic [1:0] a,
                        input logic [1:0] b, input logic [1:0] pcs,
                        input logic [1:0] ms, input logic [2:0] rws);
    chk(tag,
        {12'd0, en, bus.alu_operation, bus.alu_a_select, bus.alu_b_select,
         bus.program_counter_select, bus.memory_address_select,
         bus.register_write_data_select},
        {12'd0, e, op, a, b, pcs, ms, rws});
  endtask

  // from a FETCH negedge, run up to the EXECUTE negedge
  task automatic exec(input logic [15:0] ins);
    chk("fetch_idle", {26'd0, en}, 32'd0);
    bus.instruction = ins;
    tick();
    chk("fetch_wait_ir", {26'd0, en}, {26'd0, IR});
    tick();
    chk("decode_idle", {26'd0, en}, 32'd0);
    tick();
  endtask

  initial begin
    bus.instruction = 16'h0351;
    tick();
    tick();
    chk("reset_en", {26'd0, en}, 32'd0);
    chk("reset_sel", {9'd0, sels}, 32'd0);
    reset = 1'b0;

    exec(16'h0351);
    chk_ex("add", PC | ST | RG, 3'd0, 2'd1, 2'd0, 2'd0, 2'd0, 3'd0);
    tick();

    exec(16'h4204);
    chk_ex("load_ex", 6'd0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd1, 3'd0);
    tick();
    chk_ex("load_wait", PC | RG, 3'd0, 2'd0, 2'd0, 2'd0, 2'd1, 3'd4);
    tick();

    exec(16'h4E81);
    chk_ex("jal", PC | RG, 3'd4, 2'd1, 2'd3, 2'd1, 2'd0, 3'd5);
    tick();

    exec(16'h4345);
    chk_ex("stor", PC | MW, 3'd0, 2'd0, 2'd0, 2'd0, 2'd2, 3'd0);
    chk("stor_off", {29'd0, bus.memory_offset}, 32'd0);
    tick();

    exec(16'h02B1);
    chk_ex("cmp", PC | ST, 3'd2, 2'd1, 2'd0, 2'd0, 2'd0, 3'd0);
    tick();
    exec(16'h0331);
    chk_ex("xor", PC | RG, 3'd5, 2'd1, 2'd0, 2'd0, 2'd0, 3'd0);
    tick();
    exec(16'h03D1);
    chk_ex("mov", PC | RG, 3'd0, 2'd1, 2'd0, 2'd0, 2'd0, 3'd1);
    tick();
    exec(16'h13FF);
    chk_ex("andi", PC | RG, 3'd3, 2'd3, 2'd0, 2'd0, 2'd0, 3'd0);
    tick();
    exec(16'h2300);
    chk_ex("ori", PC | RG, 3'd4, 2'd3, 2'd0, 2'd0, 2'd0, 3'd0);
    tick();
    exec(16'h9301);
    chk_ex("subi", PC | ST | RG, 3'd1, 2'd2, 2'd0, 2'd0, 2'd0, 3'd0);
    tick();
    exec(16'hB3F0);
    chk_ex("cmpi", PC | ST, 3'd2, 2'd2, 2'd0, 2'd0, 2'd0, 3'd0);
    tick();
    exec(16'hE302);
    chk_ex("muli", PC | RG, 3'd7, 2'd2, 2'd0, 2'd0, 2'd0, 3'd0);
    tick();
    exec(16'hD305);
    chk_ex("movi", PC | RG, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd2);
    tick();
    exec(16'hF312);
    chk_ex("lui", PC | RG, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd3);
    tick();
    exec(16'h8341);
    chk_ex("lsh", PC | RG, 3'd6, 2'd1, 2'd0, 2'd0, 2'd0, 3'd0);
    tick();
    exec(16'h8301);
    chk_ex("lshi", PC | RG, 3'd6, 2'd2, 2'd0, 2'd0, 2'd0, 3'd0);
    tick();
    exec(16'hC004);
    chk_ex("bcond", PC, 3'd0, 2'd0, 2'd2, 2'd1, 2'd0, 3'd0);
    tick();
    exec(16'h40C5);
    chk_ex("jcond", PC, 3'd0, 2'd0, 2'd0, 2'd2, 2'd0, 3'd0);
    tick();
    exec(16'h6000);
    chk_ex("nop_op6", PC, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0);
    chk("nop_sel", {9'd0, sels}, 32'd0);
    tick();

    // reset during LOAD_WAIT aborts the register write
    exec(16'h4204);
    tick();
    reset = 1'b1;
    #1;
    chk("load_abort_en", {26'd0, en}, 32'd0);
    tick();
    reset = 1'b0;

`ifdef CONTROL_FSM_RAYCAST_EN
    exec(16'h7501);
    chk_ex("sin", PC | RG, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd7);
    chk("sin_x", {29'd0, bus.register_write_data_select_extra}, 32'd0);
    tick();
    exec(16'h7511);
    chk("cos_x", {29'd0, bus.register_write_data_select_extra}, 32'd1);
    tick();
    exec(16'h7551);
    chk("dist_x", {29'd0, bus.register_write_data_select_extra}, 32'd2);
    tick();
    exec(16'h7531);
    chk_ex("rayp2", PC | RY, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0);
    chk("rayp2_sel", {29'd0, bus.raycast_write_select}, 32'd2);
    tick();

    // reset at c=2 of RAYLD: strobes drop at once, no later writes
    exec(16'h7540);
    tick();
    tick();
    tick();
    chk("rayld_c2_we", {31'd0, bus.raycast_write_enable}, 32'd1);
    begin
      int rc0;
      rc0 = ray_count;
      reset = 1'b1;
      #1;
      chk("ray_abort_en", {26'd0, en}, 32'd0);
      chk("ray_abort_sel", {9'd0, sels}, 32'd0);
      tick();
      tick();
      chk("ray_abort_writes", ray_count, rc0);
    end
    reset = 1'b0;

    exec(16'h7540);
    chk("rayld_ex", {26'd0, en}, 32'd0);
    begin
      int nw;
      nw = 0;
      for (int c = 0; c <= 4; c++) begin
        tick();
        chk($sformatf("rayld_ma%0d", c),
            {30'd0, bus.memory_address_select}, (c < 4) ? 32'd2 : 32'd0);
        chk($sformatf("rayld_off%0d", c),
            {29'd0, bus.memory_offset}, (c < 4) ? c : 0);
        chk($sformatf("rayld_rsel%0d", c),
            {29'd0, bus.raycast_write_select}, (c >= 1) ? c + 3 : 0);
        chk($sformatf("rayld_pc%0d", c),
            {31'd0, bus.program_counter_write_enable}, (c == 4) ? 1 : 0);
        nw += int'(bus.raycast_write_enable);
      end
      chk("rayld_writes", nw, 4);
    end
    tick();
`else
    exec(16'h7501);
    chk_ex("sin_off", PC, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0);
    tick();
    exec(16'h7540);
    chk_ex("rayld_off", PC, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0);
    chk("rayld_off_sel", {9'd0, sels}, 32'd0);
    tick();
`endif

    exec(16'h0351);
    chk_ex("add_last", PC | ST | RG, 3'd0, 2'd1, 2'd0, 2'd0, 2'd0, 3'd0);
    tick();
    chk("final_fetch", {26'd0, en}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
